// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared encodings for the memory-stage load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_rsvd = 2'b11;

  localparam logic [1:0] c_exc_none     = 2'b00;
  localparam logic [1:0] c_exc_misalign = 2'b01;
  localparam logic [1:0] c_exc_timeout  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_aligner.sv
// ============================================================================
// Module  : load_aligner
// Brief   : Shifts the addressed lane of a read word down and extends it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_aligner
  import mem_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      c_size_byte: o_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      c_size_half: o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:     o_data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM-stage load/store unit: bus request/ready transaction, lane
//           steering, load alignment. MISALIGN_TRAP_EN enables misalign traps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        mem_flush,
  output logic [31:0] ld_data,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [8:0]  w_cnt_inc;
  logic        w_access;
  logic        w_trap;
  logic        w_timeout;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_aligned;
  logic [3:0]  w_be;

  assign w_access  = ex_valid & (ex_memread | ex_memwrite);
  assign w_size    = (ex_size == c_size_rsvd) ? c_size_word : ex_size;
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

`ifdef MISALIGN_TRAP_EN
  assign w_trap = ((w_size == c_size_half) & ex_addr[0]) |
                  ((w_size == c_size_word) & (ex_addr[1:0] != 2'b00));
  assign w_addr = ex_addr;
`else
  assign w_trap = 1'b0;
  // Misaligned low bits are dropped so the access lands on its natural boundary.
  always_comb begin
    w_addr = ex_addr;
    if (w_size == c_size_half)
      w_addr[0] = 1'b0;
    else if (w_size == c_size_word)
      w_addr[1:0] = 2'b00;
  end
`endif

  always_comb begin
    w_be    = 4'hF;
    w_wdata = ex_wdata;
    case (w_size)
      c_size_byte: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      c_size_half: begin
        w_be    = 4'b0011 << w_addr[1:0];
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_state_next = w_trap ? ST_RESP : ST_REQ;
          stall        = ~w_trap;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        // Ready takes priority over an expiring timeout in the same cycle.
        if (bus_ready) begin
          w_state_next = ST_RESP;
        end else if (w_cnt_inc == TIMEOUT_CYC[8:0]) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  load_aligner u_load_aligner (
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_rdata    (bus_rdata),
    .o_data     (w_ld_aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_lane     <= 2'b00;
      r_size     <= c_size_byte;
      r_unsigned <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_be     <= 4'd0;
      ld_data    <= 32'd0;
      exc        <= 1'b0;
      exc_code   <= c_exc_none;
      mem_flush  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      exc       <= 1'b0;
      exc_code  <= c_exc_none;
      mem_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_trap) begin
              exc       <= 1'b1;
              exc_code  <= c_exc_misalign;
              mem_flush <= 1'b1;
            end else begin
              bus_req    <= 1'b1;
              bus_we     <= ex_memwrite;
              bus_addr   <= w_addr;
              bus_wdata  <= w_wdata;
              bus_be     <= w_be;
              r_lane     <= w_addr[1:0];
              r_size     <= w_size;
              r_unsigned <= ex_unsigned;
              r_cnt      <= 8'd0;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= w_cnt_inc[7:0];
          if (bus_ready) begin
            bus_req <= 1'b0;
            if (!bus_we)
              ld_data <= w_ld_aligned;
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            exc       <= 1'b1;
            exc_code  <= c_exc_timeout;
            mem_flush <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Scoreboard bench for mem_access_unit with TIMEOUT_CYC = 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_memread, ex_memwrite, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall, mem_flush, exc, bus_req, bus_we, bus_ready;
  logic [1:0]  exc_code;
  logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_size     (ex_size),
    .ex_unsigned (ex_unsigned),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .stall       (stall),
    .mem_flush   (mem_flush),
    .ld_data     (ld_data),
    .exc         (exc),
    .exc_code    (exc_code),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] ld;
    logic        exc;
    logic [1:0]  code;
    logic        flush;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  int        checks = 0;
  int        errors = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] c_ld_after_mis = 32'h1234_5678;
`else
  localparam logic [31:0] c_ld_after_mis = 32'hCAFE_F00D;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bus_exp_t mk_bus(input logic [31:0] a, input logic we,
                                      input logic [3:0] be, input logic [31:0] wd);
    bus_exp_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wd;
    return b;
  endfunction

  function automatic resp_exp_t mk_resp(input logic [31:0] ld, input logic e,
                                        input logic [1:0] c, input logic f);
    resp_exp_t r;
    r.ld = ld; r.exc = e; r.code = c; r.flush = f;
    return r;
  endfunction

  // Monitor: response cycle follows a handshake, or is flagged by exc/mem_flush.
  initial begin
    logic resp_pending;
    bus_exp_t  b;
    resp_exp_t r;
    resp_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        resp_pending = 1'b0;
      end else begin
        if (resp_pending || exc || mem_flush) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            r = resp_q.pop_front();
            chk("resp_ld_data", ld_data, r.ld);
            chk("resp_exc", {31'd0, exc}, {31'd0, r.exc});
            chk("resp_exc_code", {30'd0, exc_code}, {30'd0, r.code});
            chk("resp_mem_flush", {31'd0, mem_flush}, {31'd0, r.flush});
          end
        end
        resp_pending = bus_req && bus_ready;
        if (bus_req && bus_ready) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
            chk("bus_be", {28'd0, bus_be}, {28'd0, b.be});
            chk("bus_wdata", bus_wdata, b.wdata);
          end
        end
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; ready_at is the REQ cycle index (1-based) of bus_ready.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ready_at, input logic [31:0] rdata,
                            input int exp_stall, input int exp_req,
                            input bit push_bus, input bus_exp_t be_exp,
                            input bit push_resp, input resp_exp_t r_exp);
    int  n_stall;
    int  n_req;
    bit  done;
    if (push_bus)  bus_q.push_back(be_exp);
    if (push_resp) resp_q.push_back(r_exp);
    ex_valid = 1'b1; ex_memread = rd; ex_memwrite = wr;
    ex_size = sz; ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata;
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus_ready = (ready_at > 0) && (cyc == ready_at);
      bus_rdata = rdata;
      @(negedge clk);
      if (stall) n_stall++; else done = 1'b1;
      if (bus_req) n_req++;
      @(posedge clk); #1;
      if (cyc == 0) ex_valid = 1'b0;
      bus_ready = 1'b0;
      if (done) break;
    end
    chk({tag, "_stall_cycles"}, n_stall, exp_stall);
    chk({tag, "_req_cycles"}, n_req, exp_req);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_size = 2'b00; ex_unsigned = 1'b0; ex_addr = 32'd0; ex_wdata = 32'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_exc", {29'd0, exc, exc_code}, 32'd0);
    chk("rst_mem_flush", {31'd0, mem_flush}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_access("word_load", 1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 3, 2,
               1, mk_bus(32'h100, 0, 4'hF, 32'h0), 1, mk_resp(32'hDEAD_BEEF, 0, 2'b00, 0));
    run_access("sbyte_load", 1, 0, 2'b00, 0, 32'h103, 32'h0, 1, 32'h8011_2233, 2, 1,
               1, mk_bus(32'h103, 0, 4'b1000, 32'h0), 1, mk_resp(32'hFFFF_FF80, 0, 2'b00, 0));
    run_access("ubyte_load", 1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h8011_2233, 2, 1,
               1, mk_bus(32'h103, 0, 4'b1000, 32'h0), 1, mk_resp(32'h0000_0080, 0, 2'b00, 0));
    run_access("half_store", 0, 1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 1, 32'h5555_5555, 2, 1,
               1, mk_bus(32'h202, 1, 4'b1100, 32'hABCD_ABCD), 1, mk_resp(32'h0000_0080, 0, 2'b00, 0));
    run_access("shalf_load", 1, 0, 2'b01, 0, 32'h202, 32'h0, 1, 32'h8001_7FFF, 2, 1,
               1, mk_bus(32'h202, 0, 4'b1100, 32'h0), 1, mk_resp(32'hFFFF_8001, 0, 2'b00, 0));
    run_access("byte_store", 0, 1, 2'b00, 0, 32'h101, 32'hFFFF_FF5A, 1, 32'h0, 2, 1,
               1, mk_bus(32'h101, 1, 4'b0010, 32'h5A5A_5A5A), 1, mk_resp(32'hFFFF_8001, 0, 2'b00, 0));
    run_access("timeout", 1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0, 5, 4,
               0, mk_bus(32'h0, 0, 4'h0, 32'h0), 1, mk_resp(32'hFFFF_8001, 1, 2'b10, 1));
    run_access("ready_at_limit", 1, 0, 2'b10, 0, 32'h304, 32'h0, 4, 32'h1234_5678, 5, 4,
               1, mk_bus(32'h304, 0, 4'hF, 32'h0), 1, mk_resp(32'h1234_5678, 0, 2'b00, 0));
`ifdef MISALIGN_TRAP_EN
    run_access("misaligned", 1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'hCAFE_F00D, 0, 0,
               0, mk_bus(32'h0, 0, 4'h0, 32'h0), 1, mk_resp(32'h1234_5678, 1, 2'b01, 1));
`else
    run_access("misaligned", 1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'hCAFE_F00D, 2, 1,
               1, mk_bus(32'h100, 0, 4'hF, 32'h0), 1, mk_resp(32'hCAFE_F00D, 0, 2'b00, 0));
`endif
    run_access("rd_wr_store", 1, 1, 2'b10, 0, 32'h400, 32'h1111_2222, 1, 32'h9999_9999, 2, 1,
               1, mk_bus(32'h400, 1, 4'hF, 32'h1111_2222), 1, mk_resp(c_ld_after_mis, 0, 2'b00, 0));
    run_access("size11_load", 1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 32'h0BAD_F00D, 2, 1,
               1, mk_bus(32'h8, 0, 4'hF, 32'h0), 1, mk_resp(32'h0BAD_F00D, 0, 2'b00, 0));
    run_access("non_mem", 0, 0, 2'b10, 0, 32'h500, 32'h0, 1, 32'h0, 0, 0,
               0, mk_bus(32'h0, 0, 4'h0, 32'h0), 0, mk_resp(32'h0, 0, 2'b00, 0));

    bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_ready_bus_req", {31'd0, bus_req}, 32'd0);
    chk("idle_ready_stall", {31'd0, stall}, 32'd0);
    chk("idle_ready_ld_data", ld_data, 32'h0BAD_F00D);
    @(posedge clk); #1;
    bus_ready = 1'b0;

    // Reset during the second REQ cycle of a never-acknowledged load.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_size = 2'b10; ex_addr = 32'h600;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk("mid_rst_ld_data", ld_data, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);

    repeat (3) @(posedge clk);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
